// File: rtl/multicycle_ctrl_pkg.sv
//============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared definitions for the multi-cycle MIPS controller.
//               Contains the state encoding (4-bit, IDLE = 0), opcode
//               constants, ALUOp / ALUSrcB / PCSource encodings, the
//               opcode class produced by op_decode, and the control word
//               produced in each state.
//               Also used by the datapath and the bench.
//               Optional feature macro elsewhere in the slice: DMEM_STALL_EN.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_WB_R     = 4'd4,
        ST_EXEC_I   = 4'd5,
        ST_WB_I     = 4'd6,
        ST_MEM_ADDR = 4'd7,
        ST_MEM_RD   = 4'd8,
        ST_WB_MEM   = 4'd9,
        ST_MEM_WR   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12
    } state_e;

    // Opcodes (IR[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;

    // ALUOp, matching the existing ALU_Control block
    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    // ALU operand B select
    localparam logic [1:0] c_SRCB_B      = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR   = 2'b01;
    localparam logic [1:0] c_SRCB_IMM    = 2'b10;
    localparam logic [1:0] c_SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_ADDI    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } op_class_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       busy;
    } ctrl_t;

    // Moore control word for a state; anything not listed stays 0.
    function automatic ctrl_t ctrl_for_state(input state_e st);
        ctrl_t ctl;
        ctl      = '0;
        ctl.busy = (st != ST_IDLE);
        case (st)
            ST_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.ir_write  = 1'b1;
                ctl.alu_src_b = c_SRCB_FOUR;
                ctl.alu_op    = c_ALUOP_ADD;
                ctl.pc_write  = 1'b1;
                ctl.pc_source = c_PCSRC_ALU;
            end
            ST_DECODE: begin
                // Speculative branch target into ALUOut
                ctl.alu_src_b = c_SRCB_IMM_SH;
                ctl.alu_op    = c_ALUOP_ADD;
            end
            ST_EXEC_R: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = c_SRCB_B;
                ctl.alu_op    = c_ALUOP_FUNCT;
            end
            ST_WB_R: begin
                ctl.reg_dst   = 1'b1;
                ctl.reg_write = 1'b1;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = c_SRCB_IMM;
                ctl.alu_op    = c_ALUOP_ADD;
            end
            ST_WB_I: begin
                ctl.reg_write = 1'b1;
            end
            ST_MEM_RD: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
            end
            ST_WB_MEM: begin
                ctl.mem_to_reg = 1'b1;
                ctl.reg_write  = 1'b1;
            end
            ST_MEM_WR: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
            end
            ST_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_src_b     = c_SRCB_B;
                ctl.alu_op        = c_ALUOP_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = c_PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = c_PCSRC_JUMP;
            end
            default: ;
        endcase
        return ctl;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
//============================================================================
// Module      : multicycle_ctrl_if
// Description : Bundle between the multi-cycle controller and its datapath.
//               master = controller side, slave = datapath side.
//               Inputs to controller : start_i, op_i, mem_ready_i (only when
//                                      DMEM_STALL_EN is defined)
//               Outputs of controller: mux selects, write enables, busy_o,
//                                      illegal_o, retired_o[CNT_W-1:0]
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             start_i;
    logic [5:0]       op_i;
`ifdef DMEM_STALL_EN
    logic             mem_ready_i;
`endif
    logic             pc_write_o;
    logic             pc_write_cond_o;
    logic             i_or_d_o;
    logic             mem_read_o;
    logic             mem_write_o;
    logic             ir_write_o;
    logic             mem_to_reg_o;
    logic             reg_dst_o;
    logic             reg_write_o;
    logic             alu_src_a_o;
    logic [1:0]       alu_src_b_o;
    logic [1:0]       alu_op_o;
    logic [1:0]       pc_source_o;
    logic             busy_o;
    logic             illegal_o;
    logic [CNT_W-1:0] retired_o;

    modport master (
        input  start_i,
        input  op_i,
`ifdef DMEM_STALL_EN
        input  mem_ready_i,
`endif
        output pc_write_o,
        output pc_write_cond_o,
        output i_or_d_o,
        output mem_read_o,
        output mem_write_o,
        output ir_write_o,
        output mem_to_reg_o,
        output reg_dst_o,
        output reg_write_o,
        output alu_src_a_o,
        output alu_src_b_o,
        output alu_op_o,
        output pc_source_o,
        output busy_o,
        output illegal_o,
        output retired_o
    );

    modport slave (
        output start_i,
        output op_i,
`ifdef DMEM_STALL_EN
        output mem_ready_i,
`endif
        input  pc_write_o,
        input  pc_write_cond_o,
        input  i_or_d_o,
        input  mem_read_o,
        input  mem_write_o,
        input  ir_write_o,
        input  mem_to_reg_o,
        input  reg_dst_o,
        input  reg_write_o,
        input  alu_src_a_o,
        input  alu_src_b_o,
        input  alu_op_o,
        input  pc_source_o,
        input  busy_o,
        input  illegal_o,
        input  retired_o
    );

endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl_op_decode.sv
//============================================================================
// Module      : op_decode
// Description : Combinational opcode classifier for the DECODE dispatch.
//               i_op      [5:0] opcode IR[31:26]
//               o_class         instruction class (op_class_e)
//               o_illegal       opcode not supported
//               No configuration macros (DMEM_STALL_EN has no effect here).
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module op_decode
    import cpu_ctrl_pkg::*;
(
    input  wire logic [5:0] i_op,
    output op_class_e       o_class,
    output logic            o_illegal
);

    op_class_e w_class;

    always_comb begin
        w_class = CLS_ILLEGAL;
        case (i_op)
            c_OP_RTYPE: w_class = CLS_RTYPE;
            c_OP_LW:    w_class = CLS_LOAD;
            c_OP_SW:    w_class = CLS_STORE;
            c_OP_BEQ:   w_class = CLS_BRANCH;
            c_OP_J:     w_class = CLS_JUMP;
            c_OP_ADDI:  w_class = CLS_ADDI;
            default:    w_class = CLS_ILLEGAL;
        endcase
    end

    assign o_class   = w_class;
    assign o_illegal = (w_class == CLS_ILLEGAL);

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
//============================================================================
// Module      : multicycle_ctrl
// Description : Moore FSM sequencing a multi-cycle MIPS datapath (shared
//               memory, IR, A/B/ALUOut/MDR, one ALU) and counting retired
//               instructions.
//               clk_i      clock, rising edge
//               rst_i      synchronous, active-high reset
//               bus        multicycle_ctrl_if.master: start_i, op_i,
//                          [mem_ready_i], control outputs, busy_o,
//                          illegal_o, retired_o
//               CNT_W      width of the retired-instruction counter
//               DMEM_STALL_EN (macro): FETCH/MEM_RD/MEM_WR wait for
//                          mem_ready_i; otherwise they last one cycle.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    multicycle_ctrl_if.master bus
);

    state_e           r_state;
    state_e           w_next_state;
    ctrl_t            r_ctl;
    logic [CNT_W-1:0] r_retired;
    logic             w_retire;
    logic             w_mem_ready;
    logic             w_illegal;
    op_class_e        w_class;

    op_decode u_op_decode (
        .i_op      (bus.op_i),
        .o_class   (w_class),
        .o_illegal (w_illegal)
    );

`ifdef DMEM_STALL_EN
    assign w_mem_ready = bus.mem_ready_i;
`else
    assign w_mem_ready = 1'b1;
`endif

    // Next state. w_retire marks the last cycle of an instruction; that
    // cycle re-samples start_i to choose between FETCH and IDLE.
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        case (r_state)
            ST_IDLE:     if (bus.start_i) w_next_state = ST_FETCH;
            ST_FETCH:    if (w_mem_ready) w_next_state = ST_DECODE;
            ST_DECODE: begin
                case (w_class)
                    CLS_RTYPE:            w_next_state = ST_EXEC_R;
                    CLS_LOAD, CLS_STORE:  w_next_state = ST_MEM_ADDR;
                    CLS_BRANCH:           w_next_state = ST_BRANCH;
                    CLS_JUMP:             w_next_state = ST_JUMP;
                    CLS_ADDI:             w_next_state = ST_EXEC_I;
                    default:              w_retire     = 1'b1;
                endcase
            end
            ST_EXEC_R:   w_next_state = ST_WB_R;
            ST_EXEC_I:   w_next_state = ST_WB_I;
            ST_MEM_ADDR: w_next_state = (w_class == CLS_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   if (w_mem_ready) w_next_state = ST_WB_MEM;
            ST_MEM_WR:   if (w_mem_ready) w_retire = 1'b1;
            ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP:
                         w_retire = 1'b1;
            default:     w_next_state = ST_IDLE;
        endcase
        if (w_retire) begin
            w_next_state = bus.start_i ? ST_FETCH : ST_IDLE;
        end
    end

    // The control word is registered from the next state so every output
    // is a flop that reflects the state being entered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_ctl     <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            r_ctl   <= ctrl_for_state(w_next_state);
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign bus.pc_write_o      = r_ctl.pc_write;
    assign bus.pc_write_cond_o = r_ctl.pc_write_cond;
    assign bus.i_or_d_o        = r_ctl.i_or_d;
    assign bus.mem_read_o      = r_ctl.mem_read;
    assign bus.mem_write_o     = r_ctl.mem_write;
    assign bus.ir_write_o      = r_ctl.ir_write;
    assign bus.mem_to_reg_o    = r_ctl.mem_to_reg;
    assign bus.reg_dst_o       = r_ctl.reg_dst;
    assign bus.reg_write_o     = r_ctl.reg_write;
    assign bus.alu_src_a_o     = r_ctl.alu_src_a;
    assign bus.alu_src_b_o     = r_ctl.alu_src_b;
    assign bus.alu_op_o        = r_ctl.alu_op;
    assign bus.pc_source_o     = r_ctl.pc_source;
    assign bus.busy_o          = r_ctl.busy;
    assign bus.retired_o       = r_retired;

    // op_i only becomes valid in DECODE, so the illegal flag cannot be
    // registered ahead of time; it is a single-cycle decode of that state.
    assign bus.illegal_o = (r_state == ST_DECODE) && w_illegal;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none

module tb_multicycle_ctrl;

    localparam int CNT_W = 2;
    localparam int N_CYC = 3000;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum int {
        P_IDLE, P_FETCH, P_DECODE, P_EXR, P_WBR, P_EXI, P_WBI,
        P_ADDR, P_MRD, P_WBM, P_MWR, P_BR, P_J
    } phase_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       busy;
        logic       illegal;
    } ctl_t;

    typedef struct {
        ctl_t             ctl;
        logic [CNT_W-1:0] ret;
        phase_t           ph;
        int               cyc;
    } sb_t;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    sb_t sb[$];

    // ---------------- reference model ----------------
    phase_t           m_phase;
    phase_t           m_list[$];
    int               m_idx;
    int               m_stall;
    int               m_inst;
    logic [5:0]       m_op;
    logic [CNT_W-1:0] m_count;
    logic [5:0]       dir_ops [7];

    function automatic bit is_illegal(input logic [5:0] op);
        return !(op == OP_R || op == OP_LW || op == OP_SW ||
                 op == OP_BEQ || op == OP_J || op == OP_ADDI);
    endfunction

    function automatic bit is_mem(input phase_t p);
        return (p == P_FETCH || p == P_MRD || p == P_MWR);
    endfunction

    function automatic ctl_t exp_ctl(input phase_t p, input bit ill);
        ctl_t e;
        e = '0;
        e.busy = (p != P_IDLE);
        case (p)
            P_FETCH:  begin e.mem_read = 1; e.ir_write = 1; e.alu_src_b = 2'b01; e.pc_write = 1; end
            P_DECODE: begin e.alu_src_b = 2'b11; end
            P_EXR:    begin e.alu_src_a = 1; e.alu_src_b = 2'b00; e.alu_op = 2'b10; end
            P_WBR:    begin e.reg_dst = 1; e.reg_write = 1; end
            P_EXI:    begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            P_WBI:    begin e.reg_write = 1; end
            P_ADDR:   begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            P_MRD:    begin e.mem_read = 1; e.i_or_d = 1; end
            P_WBM:    begin e.mem_to_reg = 1; e.reg_write = 1; end
            P_MWR:    begin e.mem_write = 1; e.i_or_d = 1; end
            P_BR:     begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_source = 2'b01; end
            P_J:      begin e.pc_write = 1; e.pc_source = 2'b10; end
            default: ;
        endcase
        e.illegal = ill;
        return e;
    endfunction

    function automatic logic [5:0] rand_op();
        logic [5:0] op;
        case ($urandom_range(0, 6))
            0: op = OP_R;
            1: op = OP_LW;
            2: op = OP_SW;
            3: op = OP_BEQ;
            4: op = OP_J;
            5: op = OP_ADDI;
            default: begin
                op = 6'($urandom_range(0, 63));
                while (!is_illegal(op)) op = 6'($urandom_range(0, 63));
            end
        endcase
        return op;
    endfunction

    function automatic int pick_stall(input phase_t p, input int inst);
`ifdef DMEM_STALL_EN
        if (inst == 1 && p == P_MRD) return 3;
        return ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
`else
        return (p == P_IDLE && inst < 0) ? 1 : 0;
`endif
    endfunction

    task automatic begin_instr();
        m_inst++;
        m_op = (m_inst < 7) ? dir_ops[m_inst] : rand_op();
        m_list.delete();
        m_list.push_back(P_FETCH);
        m_list.push_back(P_DECODE);
        case (m_op)
            OP_R:    begin m_list.push_back(P_EXR);  m_list.push_back(P_WBR); end
            OP_LW:   begin m_list.push_back(P_ADDR); m_list.push_back(P_MRD); m_list.push_back(P_WBM); end
            OP_SW:   begin m_list.push_back(P_ADDR); m_list.push_back(P_MWR); end
            OP_BEQ:  m_list.push_back(P_BR);
            OP_J:    m_list.push_back(P_J);
            OP_ADDI: begin m_list.push_back(P_EXI);  m_list.push_back(P_WBI); end
            default: ;
        endcase
        m_idx   = 0;
        m_phase = P_FETCH;
        m_stall = pick_stall(P_FETCH, m_inst);
    endtask

    // ---------------- driver + model stepping ----------------
    initial begin
        dir_ops[0] = OP_R;   dir_ops[1] = OP_LW; dir_ops[2] = OP_SW;
        dir_ops[3] = OP_BEQ; dir_ops[4] = OP_J;  dir_ops[5] = 6'b111111;
        dir_ops[6] = OP_R;
        rst_i       = 1'b1;
        bus.start_i = 1'b1;
        bus.op_i    = '0;
`ifdef DMEM_STALL_EN
        bus.mem_ready_i = 1'b1;
`endif
        m_phase = P_IDLE;
        m_count = '0;
        m_idx   = 0;
        m_stall = 0;
        m_inst  = -1;
        m_op    = '0;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            sb_t e;
            bit  n_rst, n_start, rdy;
            @(posedge clk_i);
            #1;
            e.ctl = exp_ctl(m_phase, (m_phase == P_DECODE) && is_illegal(m_op));
            e.ret = m_count;
            e.ph  = m_phase;
            e.cyc = cyc;
            sb.push_back(e);

            n_rst = (cyc < 3) || (cyc >= 600 && cyc < 602);
            if (m_inst == 6 && (m_phase == P_EXR || m_phase == P_WBR))
                n_start = 1'b0;
            else if (m_inst < 7)
                n_start = 1'b1;
            else
                n_start = ($urandom_range(0, 5) != 0);
            rdy = is_mem(m_phase) ? (m_stall == 0) : 1'($urandom_range(0, 1));

            rst_i       = n_rst;
            bus.start_i = n_start;
            bus.op_i    = (m_phase == P_IDLE || (m_phase == P_FETCH && !rdy))
                          ? 6'($urandom_range(0, 63)) : m_op;
`ifdef DMEM_STALL_EN
            bus.mem_ready_i = rdy;
`endif

            if (n_rst) begin
                m_phase = P_IDLE;
                m_count = '0;
            end else if (m_phase == P_IDLE) begin
                if (n_start) begin_instr();
            end else if (is_mem(m_phase) && !rdy) begin
                m_stall--;
            end else if (m_idx == m_list.size() - 1) begin
                m_count = m_count + 1'b1;
                if (n_start) begin_instr();
                else m_phase = P_IDLE;
            end else begin
                m_idx++;
                m_phase = m_list[m_idx];
                m_stall = pick_stall(m_phase, m_inst);
            end
        end

        @(negedge clk_i);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk_i);
            if (sb.size() > 0) begin
                sb_t  e;
                ctl_t act;
                e   = sb.pop_front();
                act = {bus.pc_write_o, bus.pc_write_cond_o, bus.i_or_d_o, bus.mem_read_o,
                       bus.mem_write_o, bus.ir_write_o, bus.mem_to_reg_o, bus.reg_dst_o,
                       bus.reg_write_o, bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o,
                       bus.pc_source_o, bus.busy_o, bus.illegal_o};
                checks++;
                if (act !== e.ctl) begin
                    errors++;
                    $display("FAIL ctrl cycle=%0d phase=%s actual=%b required=%b",
                             e.cyc, e.ph.name(), act, e.ctl);
                end
                checks++;
                if (bus.retired_o !== e.ret) begin
                    errors++;
                    $display("FAIL retired cycle=%0d phase=%s actual=%0d required=%0d",
                             e.cyc, e.ph.name(), bus.retired_o, e.ret);
                end
            end
        end
    end

endmodule

`default_nettype wire
